// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// The ALU op codes mirror the ALUCr encodings, and the arbiter FSM states
// are one bit wide. The optional build macro ALU_ARB_FIXED_PRIO_EN is
// consumed by alu_rr_pick; nothing here depends on it.
package alu_arbiter_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_EXEC = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way request picker for the ALU arbiter.
// Default build: round robin, a tie goes to the requester that was not
// served last. With ALU_ARB_FIXED_PRIO_EN defined, requester 0 always wins
// a tie and last_grant is ignored.
module alu_rr_pick
    import alu_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_id,
    output logic grant_valid
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Fixed priority: requester 0 beats requester 1 whenever both ask
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = ~req0;
    end
`else
    // Round robin: on a tie the requester not served last time wins
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the EX-stage datapath (requester 0)
// and the branch/address unit (requester 1). A granted request is latched
// into issue registers that drive the ALU; one cycle later the ALU result
// and flags are captured and returned with a one-cycle ack.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (see alu_rr_pick).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [CTRL_W-1:0] ctrl0,
    input  logic [CTRL_W-1:0] ctrl1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] res,
    output logic              res_zero,
    output logic              res_ovf,
    output logic              res_neg,
    output logic              res_id,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_negative
);

    arb_state_t        state;
    logic              last_grant;
    logic              issue_id;
    logic [CTRL_W-1:0] issue_ctrl;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic              grant_id;
    logic              grant_valid;

    alu_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign alu_a    = issue_a;
    assign alu_b    = issue_b;
    assign alu_ctrl = issue_ctrl;

    // Arbiter FSM: latch the winner's operands in IDLE, capture the ALU
    // outputs and pulse the owner's ack in EXEC. Operand changes while a
    // request is in flight never reach the ALU because issue regs only load in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            issue_id   <= 1'b0;
            issue_ctrl <= '0;
            issue_a    <= '0;
            issue_b    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            res        <= '0;
            res_zero   <= 1'b0;
            res_ovf    <= 1'b0;
            res_neg    <= 1'b0;
            res_id     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        issue_id   <= grant_id;
                        issue_ctrl <= grant_id ? ctrl1 : ctrl0;
                        issue_a    <= grant_id ? a1 : a0;
                        issue_b    <= grant_id ? b1 : b0;
                        state      <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    res        <= alu_c;
                    res_zero   <= alu_zero;
                    res_ovf    <= alu_overflow;
                    res_neg    <= alu_negative;
                    res_id     <= issue_id;
                    ack0       <= ~issue_id;
                    ack1       <= issue_id;
                    last_grant <= issue_id;
                    state      <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
